alu8: RTL and testbench
=======================

Name: alu8

Overview:
- Datapath ALU for the 8-bit pipeline core, located in the execute stage.
- R is a combinational arithmetic, logic or shift result of A and B.
- The zero and carry status flags are held in registers and are written only when the control unit asserts update_z_c.
- carry_in is the stored carry fed back by the pipeline, used by the add/sub-with-carry operations.

Parameters:
- WIDTH, 8, data width of A, B and R. Shift amount uses the low SW=$clog2(WIDTH) bits of B.

Ports:
- clk  input  1  system clock; flags update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for shifts, B[SW-1:0] is the shift amount.
- carry_in  input  1  carry/borrow input for ADDC and SUBC.
- is_shift  input  1  1 selects the shifter (scode); 0 selects the arithmetic/logic unit (acode).
- update_z_c  input  1  flag write enable.
- scode  input  2  shift opcode.
- acode  input  3  ALU opcode.
- R  output  WIDTH  combinational result.
- zero  output  1  registered zero flag.
- carry_out  output  1  registered carry flag.

Behaviour:
- R is purely combinational, with 0-cycle latency from its inputs. It is not affected by rst.
- acode, used when is_shift=0:
  - 000 ADD: R=A+B; c = carry out of bit WIDTH-1.
  - 001 ADDC: R=A+B+carry_in; c = carry out.
  - 010 SUB: R=A-B; c = borrow (1 iff A<B unsigned).
  - 011 SUBC: R=A-B-carry_in; c = borrow (1 iff A<B+carry_in unsigned).
  - 100 AND, 101 OR, 110 XOR, 111 MASK (R=A&~B).
- scode, used when is_shift=1, with n=B[SW-1:0]:
  - 00 SHL: logical left shift; zero-fill.
  - 01 SHR: logical right shift; zero-fill.
  - 10 ROL: rotate left.
  - 11 ROR: rotate right.
  - Shift carry c = last bit shifted or rotated out:
    - SHL/ROL: A[WIDTH-n].
    - SHR/ROR: A[n-1].
  - acode is ignored in shift mode; scode is ignored in ALU mode.
- Flags, on each rising clk edge:
  - rst=1: zero<=0 and carry_out<=0. Reset has priority over update_z_c.
  - else if update_z_c=1:
    - zero <= (R==0).
    - carry_out <= c for ADD/ADDC/SUB/SUBC and for shifts with n!=0.
    - carry_out holds its value for logic ops (100-111) and for shifts with n=0.
  - else both flags hold.
- Flags reflect the operation present during the cycle before the edge, so they are visible one cycle after the operation.
- Mid-operation reset clears only the flags; R continues to follow its inputs.
- No X propagation: all opcode encodings are defined.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit, registered). Reset value is 0.
  - Updated under the same rst/update_z_c rules as carry_out.
  - Value is the signed two's-complement overflow of ADD/ADDC/SUB/SUBC.
  - Holds for logic ops and shifts.
- When undefined: the port and its register do not exist, and all other behaviour is identical.

Test Plan:
- A=0xE5, B=0x07, is_shift=0, update_z_c=1, carry_in=1:
  - acode=000 -> R=0xEC; after edge carry=0, zero=0.
  - acode=001 -> R=0xED.
  - acode=010 -> R=0xDE, carry=0.
  - acode=011 -> R=0xDD.
- A=0xE5, B=0x06, is_shift=1, update_z_c=1; carry=1 after each edge:
  - scode 00 -> R=0x40.
  - scode 01 -> R=0x03.
  - scode 10 -> R=0x79.
  - scode 11 -> R=0x97.
- A=B=0x55, acode=010 -> R=0x00; next edge zero=1, carry=0. Then A=0x00, B=0x01, SUB -> R=0xFF, carry=1, zero=0.
- Carry hold and write enable:
  - Set carry=1, then acode=100 with A=0xF0, B=0x0F -> R=0x00, zero=1, carry stays 1.
  - With update_z_c=0, no flag changes for any op.
  - A shift with B=0x00 -> R=A, carry unchanged.
- rst=1 while update_z_c=1 and R=0 -> zero=0, carry=0 after the edge; R still equals the combinational result.
- With ALU_OVERFLOW_EN: A=0x7F, B=0x01, ADD -> R=0x80, overflow=1. A=0x80, B=0x01, SUB -> R=0x7F, overflow=1.

Source files
------------

// File: rtl/alu8_if.sv
// alu8_if: operand, opcode, result and flag bundle between the pipeline control and alu8
// Carries the overflow flag only when ALU_OVERFLOW_EN is defined.
interface alu8_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] A, B, R;
    logic carry_in, is_shift, update_z_c;
    logic [1:0] scode;
    logic [2:0] acode;
    logic zero, carry_out;
`ifdef ALU_OVERFLOW_EN
    logic overflow;
`endif
    modport master (
        output A, B, carry_in, is_shift, update_z_c, scode, acode,
        input R, zero, carry_out
`ifdef ALU_OVERFLOW_EN
        , overflow
`endif
    );
    modport slave (
        input A, B, carry_in, is_shift, update_z_c, scode, acode,
        output R, zero, carry_out
`ifdef ALU_OVERFLOW_EN
        , overflow
`endif
    );
endinterface

// File: rtl/alu8.sv
// alu8: combinational ALU/shifter result with registered zero/carry flags
// Optional registered signed overflow flag enabled by ALU_OVERFLOW_EN.
module alu8 #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    alu8_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] a, b, r, lg, sh;
    logic [SW-1:0] n;
    logic [WIDTH:0] add_r, sub_r, sl, sr;
    logic [2*WIDTH-1:0] rl, rr;
    logic cin, c, upd_c;
`ifdef ALU_OVERFLOW_EN
    logic v;
`endif
    assign a = bus.A;
    assign b = bus.B;
    assign bus.R = r;
    always_comb begin
        n = b[SW-1:0];
        cin = bus.acode[0] & bus.carry_in;
        add_r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        // extra guard bit catches the last bit shifted out on either side
        sl = {1'b0, a} << n;
        sr = {a, 1'b0} >> n;
        rl = {a, a} << n;
        rr = {a, a} >> n;
        lg = bus.acode[1:0] == 2'b00 ? a & b :
             bus.acode[1:0] == 2'b01 ? a | b :
             bus.acode[1:0] == 2'b10 ? a ^ b : a & ~b;
        sh = bus.scode == 2'b00 ? sl[WIDTH-1:0] :
             bus.scode == 2'b01 ? sr[WIDTH:1] :
             bus.scode == 2'b10 ? rl[2*WIDTH-1:WIDTH] : rr[WIDTH-1:0];
        r = bus.is_shift ? sh : bus.acode[2] ? lg :
            bus.acode[1] ? sub_r[WIDTH-1:0] : add_r[WIDTH-1:0];
        c = bus.is_shift ? (bus.scode[0] ? sr[0] : sl[WIDTH]) :
            bus.acode[1] ? sub_r[WIDTH] : add_r[WIDTH];
        upd_c = bus.is_shift ? n != '0 : !bus.acode[2];
`ifdef ALU_OVERFLOW_EN
        v = bus.acode[1] ? (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]) :
                           (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.zero <= 1'b0;
            bus.carry_out <= 1'b0;
        end else if (bus.update_z_c) begin
            bus.zero <= r == '0;
            if (upd_c) bus.carry_out <= c;
        end
    end
`ifdef ALU_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) bus.overflow <= 1'b0;
        else if (bus.update_z_c && !bus.is_shift && !bus.acode[2]) bus.overflow <= v;
    end
`endif
endmodule

// File: tb/tb_alu8.sv
// tb_alu8: vector table for R with a flag scoreboard checked one edge later
module tb_alu8;
    typedef struct {
        logic [7:0] a, b;
        logic cin, sh;
        logic [1:0] sc;
        logic [2:0] ac;
        logic upd;
        logic [7:0] r;
        logic z, c, v;
    } vec_t;
    typedef struct { logic z, c, v; string name; } flag_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    vec_t tv [28];
    flag_t sb [$];

    alu8_if #(.WIDTH(8)) bus ();
    alu8 #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.A = t.a; bus.B = t.b; bus.carry_in = t.cin; bus.is_shift = t.sh;
        bus.scode = t.sc; bus.acode = t.ac; bus.update_z_c = t.upd;
    endtask

    task automatic check_flags();
        flag_t f;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
            return;
        end
        f = sb.pop_front();
        chk({f.name, "_zero"}, {7'd0, bus.zero}, {7'd0, f.z});
        chk({f.name, "_carry"}, {7'd0, bus.carry_out}, {7'd0, f.c});
`ifdef ALU_OVERFLOW_EN
        chk({f.name, "_ovf"}, {7'd0, bus.overflow}, {7'd0, f.v});
`endif
    endtask

    task automatic apply(input vec_t t, input string name);
        @(negedge clk);
        drive(t);
        #1 chk({name, "_R"}, bus.R, t.r);
        sb.push_back('{t.z, t.c, t.v, name});
        @(posedge clk);
        #1 check_flags();
    endtask

    initial begin
        //            a      b      cin   sh    sc     ac      upd   r      z     c     v
        tv[0]  = '{8'hE5, 8'h07, 1'b1, 1'b0, 2'b11, 3'b000, 1'b1, 8'hEC, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{8'hE5, 8'h07, 1'b1, 1'b0, 2'b00, 3'b001, 1'b1, 8'hED, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{8'hE5, 8'h07, 1'b1, 1'b0, 2'b10, 3'b010, 1'b1, 8'hDE, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{8'hE5, 8'h07, 1'b1, 1'b0, 2'b00, 3'b011, 1'b1, 8'hDD, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{8'hE5, 8'h06, 1'b0, 1'b1, 2'b00, 3'b111, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{8'hE5, 8'h06, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{8'hE5, 8'h06, 1'b0, 1'b1, 2'b10, 3'b010, 1'b1, 8'h79, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{8'hE5, 8'h06, 1'b0, 1'b1, 2'b11, 3'b100, 1'b1, 8'h97, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{8'h55, 8'h55, 1'b1, 1'b0, 2'b00, 3'b010, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{8'h00, 8'h01, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        tv[10] = '{8'hF0, 8'h0F, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[11] = '{8'hF0, 8'h0F, 1'b0, 1'b0, 2'b00, 3'b101, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
        tv[12] = '{8'hFF, 8'h01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[13] = '{8'hFF, 8'h01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[14] = '{8'h3C, 8'h08, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        tv[15] = '{8'hF3, 8'h30, 1'b0, 1'b0, 2'b00, 3'b111, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0};
        tv[16] = '{8'h01, 8'h01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        tv[17] = '{8'hFF, 8'h00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[18] = '{8'h10, 8'h0F, 1'b1, 1'b0, 2'b00, 3'b011, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tv[19] = '{8'h0F, 8'h0F, 1'b1, 1'b0, 2'b00, 3'b011, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        tv[20] = '{8'h01, 8'h01, 1'b0, 1'b1, 2'b11, 3'b000, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
        tv[21] = '{8'h80, 8'h07, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        tv[22] = '{8'h02, 8'h07, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[23] = '{8'h7F, 8'h01, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
        tv[24] = '{8'h81, 8'h00, 1'b0, 1'b1, 2'b10, 3'b000, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1};
        tv[25] = '{8'h80, 8'h01, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1};
        tv[26] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 2'b00, 3'b110, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[27] = '{8'h01, 8'h01, 1'b0, 1'b0, 2'b00, 3'b001, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};

        drive(tv[8]);
        repeat (2) @(posedge clk);
        #1 chk("reset_zero", {7'd0, bus.zero}, 8'd0);
        chk("reset_carry", {7'd0, bus.carry_out}, 8'd0);
`ifdef ALU_OVERFLOW_EN
        chk("reset_ovf", {7'd0, bus.overflow}, 8'd0);
`endif
        chk("reset_R_comb", bus.R, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) apply(tv[i], $sformatf("vec%0d", i));

        // reset mid-operation with flags set: only flags clear, R keeps following inputs
        apply(tv[13], "pre_rst");
        @(negedge clk);
        rst = 1'b1;
        drive(tv[8]);
        #1 chk("rst_R", bus.R, 8'h00);
        sb.push_back('{1'b0, 1'b0, 1'b0, "rst_mid"});
        @(posedge clk);
        #1 check_flags();
        bus.A = 8'h56;
        #1 chk("rst_R_follow", bus.R, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        apply(tv[27], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
